fir_tap_controller: RTL and testbench

//  Sequencer and coefficient manager for a direct-form FIR chain of N_TAPS tapped delay stages.
//  - Accepts input samples on a valid/ready handshake and drives them into the head of the chain.
//  - Pulses the chain shift enable and registers the chain's combinational sum as the output sample.
//  - Double-buffers the coefficient set and flushes the delay line on every coefficient commit.

---
 rtl/fir_ctrl_pkg.sv | 33 +++
 rtl/fir_coef_bank.sv | 59 +++++
 rtl/fir_tap_controller.sv | 141 ++++++++++++++
 tb/tb_fir_tap_controller.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fir_ctrl_pkg
// Shared types and helpers for the FIR tap controller and its coefficient bank.
//   state_t   : controller sequencing states
//   coef_t    : default-width signed coefficient
//   sample_t  : default-width signed input sample
//   acc_t     : default-width signed accumulator / output sample
//   idx_width : width of the coefficient address port for a given tap count
// -----------------------------------------------------------------------------
package fir_ctrl_pkg;

  localparam int L_DEF      = 24;
  localparam int M_DEF      = 16;
  localparam int A_DEF      = 46;
  localparam int N_TAPS_DEF = 8;

  typedef enum logic [1:0] {
    S_UNCFG = 2'd0,
    S_FLUSH = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  typedef logic signed [M_DEF-1:0] coef_t;
  typedef logic signed [L_DEF-1:0] sample_t;
  typedef logic signed [A_DEF-1:0] acc_t;

  // One bit wider than the bare tap index so that out-of-range addresses can
  // actually be presented on the port (and are then dropped by the bank).
  function automatic int idx_width(input int n_taps);
    return $clog2(n_taps) + 1;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// -----------------------------------------------------------------------------
// fir_coef_bank
// Double-buffered coefficient storage. Writes land in the shadow bank; a copy
// pulse moves the whole shadow bank into the active bank, which alone drives
// the flattened coefficient bus.
// Ports:
//   clk        : clock
//   rst        : synchronous reset, active-low (clears both banks)
//   i_we       : shadow write enable
//   i_addr     : shadow index; indices >= N_TAPS match no tap and are dropped
//   i_data     : coefficient value
//   i_copy     : copy shadow -> active this cycle
//   o_coef_bus : active coefficients, tap k at [k*M +: M]
// -----------------------------------------------------------------------------
module fir_coef_bank
  import fir_ctrl_pkg::*;
#(
  parameter int M      = 16,
  parameter int N_TAPS = 8,
  parameter int AW     = idx_width(8)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_we,
  input  logic [AW-1:0]       i_addr,
  input  logic [M-1:0]        i_data,
  input  logic                i_copy,
  output logic [N_TAPS*M-1:0] o_coef_bus
);

  genvar gi;
  generate
    for (gi = 0; gi < N_TAPS; gi++) begin : g_tap
      logic [M-1:0] r_shadow;
      logic [M-1:0] r_active;
      logic         w_hit;

      assign w_hit = i_we && (i_addr == AW'(gi));

      always_ff @(posedge clk) begin
        if (!rst) begin
          r_shadow <= '0;
          r_active <= '0;
        end else begin
          if (w_hit) begin
            r_shadow <= i_data;
          end
          // A write in the copy cycle is forwarded so it becomes part of the commit.
          if (i_copy) begin
            r_active <= w_hit ? i_data : r_shadow;
          end
        end
      end

      assign o_coef_bus[gi*M +: M] = r_active;
    end
  endgenerate

endmodule

// File: rtl/fir_tap_controller.sv
// -----------------------------------------------------------------------------
// fir_tap_controller
// Sequencer for a direct-form FIR chain: takes samples on a valid/ready
// handshake, pushes them into the chain head, registers the chain's
// combinational sum as the output sample, and flushes the delay line with
// zeros whenever a new coefficient set is committed.
// Ports:
//   clk, rst            : clock, synchronous active-low reset
//   cfg_we/addr/data    : shadow coefficient write
//   cfg_commit          : request shadow -> active copy (sticky until done)
//   s_valid/s_ready/s_data : input sample handshake
//   chain_x, chain_ena  : sample and shift enable into the chain
//   coef_bus            : active coefficients to the chain
//   chain_y             : combinational chain sum
//   m_valid/m_ready/m_data : output sample handshake
//   busy                : high while unconfigured or flushing
// -----------------------------------------------------------------------------
module fir_tap_controller
  import fir_ctrl_pkg::*;
#(
  parameter  int L      = 24,
  parameter  int M      = 16,
  parameter  int A      = 46,
  parameter  int N_TAPS = 8,
  localparam int AW     = idx_width(N_TAPS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [M-1:0]        cfg_data,
  input  logic                cfg_commit,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [L-1:0]        s_data,
  output logic [L-1:0]        chain_x,
  output logic                chain_ena,
  output logic [N_TAPS*M-1:0] coef_bus,
  input  logic [A-1:0]        chain_y,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [A-1:0]        m_data,
  output logic                busy
);

  localparam int CW = $clog2(N_TAPS);

  state_t        r_state;
  logic [CW-1:0] r_flush_cnt;
  logic          r_commit_pend;
  logic          r_m_valid;
  logic [A-1:0]  r_m_data;

  logic w_accept;
  logic w_copy;
  logic w_flush_done;

  assign s_ready  = (r_state == S_RUN) && !r_commit_pend && (!r_m_valid || m_ready);
  assign w_accept = s_valid && s_ready;

  // The copy waits for the output register to drain so no in-flight result
  // is ever paired with a coefficient set it was not computed with.
  assign w_copy = r_commit_pend &&
                  ((r_state == S_UNCFG) ||
                   ((r_state == S_RUN) && !r_m_valid && !w_accept));

  assign w_flush_done = (r_flush_cnt == CW'(N_TAPS - 1));

  assign chain_x   = w_accept ? s_data : '0;
  assign chain_ena = w_accept || (r_state == S_FLUSH);
  assign busy      = (r_state != S_RUN);
  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;

  fir_coef_bank #(
    .M      (M),
    .N_TAPS (N_TAPS),
    .AW     (AW)
  ) u_coef_bank (
    .clk        (clk),
    .rst        (rst),
    .i_we       (cfg_we),
    .i_addr     (cfg_addr),
    .i_data     (cfg_data),
    .i_copy     (w_copy),
    .o_coef_bus (coef_bus)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_UNCFG;
      r_flush_cnt   <= '0;
      r_commit_pend <= 1'b0;
      r_m_valid     <= 1'b0;
      r_m_data      <= '0;
    end else begin
      // A new commit always wins over clearing, so a commit that coincides
      // with a copy schedules one more copy/flush afterwards.
      if (cfg_commit) begin
        r_commit_pend <= 1'b1;
      end else if (w_copy) begin
        r_commit_pend <= 1'b0;
      end

      case (r_state)
        S_UNCFG: begin
          if (r_commit_pend) begin
            r_state     <= S_FLUSH;
            r_flush_cnt <= '0;
          end
        end
        S_FLUSH: begin
          if (w_flush_done) begin
            r_state     <= S_RUN;
            r_flush_cnt <= '0;
          end else begin
            r_flush_cnt <= r_flush_cnt + CW'(1);
          end
        end
        S_RUN: begin
          if (w_copy) begin
            r_state     <= S_FLUSH;
            r_flush_cnt <= '0;
          end
        end
        default: begin
          r_state     <= S_UNCFG;
          r_flush_cnt <= '0;
        end
      endcase

      if (w_accept) begin
        r_m_valid <= 1'b1;
        r_m_data  <= chain_y;
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_tap_controller.sv
module tb_fir_tap_controller;

  localparam int L      = 24;
  localparam int M      = 16;
  localparam int A      = 46;
  localparam int N_TAPS = 4;
  localparam int AW     = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                cfg_we;
  logic [AW-1:0]       cfg_addr;
  logic [M-1:0]        cfg_data;
  logic                cfg_commit;
  logic                s_valid;
  logic                s_ready;
  logic [L-1:0]        s_data;
  logic [L-1:0]        chain_x;
  logic                chain_ena;
  logic [N_TAPS*M-1:0] coef_bus;
  logic [A-1:0]        chain_y;
  logic                m_valid;
  logic                m_ready;
  logic [A-1:0]        m_data;
  logic                busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fir_tap_controller #(
    .L(L), .M(M), .A(A), .N_TAPS(N_TAPS)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .chain_x(chain_x), .chain_ena(chain_ena), .coef_bus(coef_bus), .chain_y(chain_y),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy)
  );

  // Tapped delay line: tap 0 sees chain_x directly, tap k sees the sample
  // shifted in k enables ago.
  logic signed [L-1:0] z [N_TAPS-1];
  always @(posedge clk) begin
    if (chain_ena) begin
      z[0] <= chain_x;
      for (int k = 1; k < N_TAPS - 1; k++) z[k] <= z[k-1];
    end
  end

  always_comb begin
    longint acc;
    acc = longint'($signed(coef_bus[0 +: M])) * longint'($signed(chain_x));
    for (int k = 1; k < N_TAPS; k++)
      acc = acc + longint'($signed(coef_bus[k*M +: M])) * longint'(z[k-1]);
    chain_y = acc[A-1:0];
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: coefficient banks, recent-sample history, output register.
  // Each output is the dot product of the active coefficients with the most
  // recent N_TAPS accepted samples (zeros after a flush).
  // ---------------------------------------------------------------------------
  longint mdl_shadow [N_TAPS];
  longint mdl_active [N_TAPS];
  longint mdl_hist   [N_TAPS];
  bit     mdl_on = 1'b0;
  bit     exp_valid;
  longint exp_data;
  bit     prev_flushing;

  always @(negedge clk) begin
    bit     flushing;
    bit     acc_now;
    longint sum;
    longint packed_exp;
    acc_now = 1'b0;
    if (mdl_on) begin
      flushing = busy && chain_ena;
      if (flushing && !prev_flushing) begin
        for (int k = 0; k < N_TAPS; k++) begin
          mdl_active[k] = mdl_shadow[k];
          mdl_hist[k]   = 0;
        end
      end
      prev_flushing = flushing;

      packed_exp = 0;
      for (int k = 0; k < N_TAPS; k++)
        packed_exp = packed_exp | ((mdl_active[k] & 64'hFFFF) << (k * M));

      chk("m_valid", longint'(m_valid), longint'(exp_valid));
      chk("m_data", longint'($signed(m_data)), exp_data);
      chk("coef_bus", longint'(coef_bus), packed_exp);

      acc_now = s_valid && s_ready;
      if (acc_now) begin
        chk("chain_x_on_accept", longint'($signed(chain_x)), longint'($signed(s_data)));
        chk("chain_ena_on_accept", longint'(chain_ena), 1);
      end else begin
        chk("chain_x_idle", longint'(chain_x), 0);
        if (!busy) chk("chain_ena_idle", longint'(chain_ena), 0);
      end
      if (s_ready) chk("ready_not_busy", longint'(busy), 0);
      if (exp_valid && !m_ready) chk("ready_blocked_by_hold", longint'(s_ready), 0);
    end

    if (!rst) begin
      mdl_on        = 1'b1;
      exp_valid     = 1'b0;
      exp_data      = 0;
      prev_flushing = 1'b0;
      for (int k = 0; k < N_TAPS; k++) begin
        mdl_shadow[k] = 0;
        mdl_active[k] = 0;
        mdl_hist[k]   = 0;
      end
    end else if (mdl_on) begin
      if (cfg_we && (int'(cfg_addr) < N_TAPS))
        mdl_shadow[cfg_addr] = longint'($signed(cfg_data));
      if (acc_now) begin
        for (int k = N_TAPS - 1; k > 0; k--) mdl_hist[k] = mdl_hist[k-1];
        mdl_hist[0] = longint'($signed(s_data));
        sum = 0;
        for (int k = 0; k < N_TAPS; k++) sum = sum + mdl_active[k] * mdl_hist[k];
        exp_valid = 1'b1;
        exp_data  = sum;
      end else if (m_ready) begin
        exp_valid = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus. Inputs change 1 time unit after posedge; checks at negedge.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
    s_valid = 1'b0; s_data = '0;
  endtask

  task automatic wait_flush(input string tag);
    int cnt;
    bit seen;
    cnt  = 0;
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      @(negedge clk);
      if (busy && chain_ena) begin
        seen = 1'b1;
        cnt++;
      end else if (seen) begin
        break;
      end
    end
    chk({tag, "_flush_len"}, cnt, N_TAPS);
    chk({tag, "_ready_after_flush"}, longint'(s_ready), 1);
  endtask

  initial begin
    longint lit [5];
    bit     seen_flush;
    lit = '{1, 2, 3, 4, 0};

    rst = 1'b0; m_ready = 1'b1;
    clr_inputs();
    repeat (3) step();
    @(negedge clk);
    chk("rst_m_valid", longint'(m_valid), 0);
    chk("rst_m_data", longint'(m_data), 0);
    chk("rst_coef_bus", longint'(coef_bus), 0);
    step();
    rst = 1'b1;

    // 1: unconfigured, input never accepted
    s_valid = 1'b1; s_data = 24'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("uncfg_s_ready", longint'(s_ready), 0);
      chk("uncfg_chain_ena", longint'(chain_ena), 0);
      chk("uncfg_busy", longint'(busy), 1);
      step();
    end
    clr_inputs();

    // 2: coefficients 1,2,3,4; commit with the last write
    for (int i = 0; i < N_TAPS; i++) begin
      step();
      cfg_we = 1'b1; cfg_addr = AW'(i); cfg_data = M'(i + 1);
      cfg_commit = (i == N_TAPS - 1);
    end
    step();
    clr_inputs();
    wait_flush("cfg1");
    chk("cfg1_coef_bus", longint'(coef_bus), 64'h0004_0003_0002_0001);

    // 3: impulse, back-to-back
    for (int j = 0; j < 6; j++) begin
      step();
      s_valid = (j < 5);
      s_data  = (j == 0) ? 24'd1 : 24'd0;
      @(negedge clk);
      if (j < 5) chk("imp_s_ready", longint'(s_ready), 1);
      if (j > 0) begin
        chk("imp_m_valid", longint'(m_valid), 1);
        chk("imp_m_data", longint'($signed(m_data)), lit[j-1]);
      end
    end

    // 4: output back-pressure
    step(); s_valid = 1'b1; s_data = 24'd5;
    @(negedge clk);
    chk("bp_accept_ready", longint'(s_ready), 1);
    for (int i = 0; i < 3; i++) begin
      step(); s_valid = 1'b1; s_data = 24'd2; m_ready = 1'b0;
      @(negedge clk);
      chk("bp_hold_valid", longint'(m_valid), 1);
      chk("bp_hold_data", longint'($signed(m_data)), 5);
      chk("bp_hold_ready", longint'(s_ready), 0);
      chk("bp_hold_ena", longint'(chain_ena), 0);
    end
    step(); m_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", longint'(s_ready), 1);
    chk("bp_release_data", longint'($signed(m_data)), 5);
    step(); s_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", longint'(m_valid), 1);
    chk("bp_next_data", longint'($signed(m_data)), 12);
    step();
    @(negedge clk);
    chk("bp_drained", longint'(m_valid), 0);

    // 5: write+commit in the same cycle as an accept
    step();
    s_valid = 1'b1; s_data = 24'd1;
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 16'hFFFB; cfg_commit = 1'b1;
    @(negedge clk);
    chk("c5_accept_ready", longint'(s_ready), 1);
    step();
    clr_inputs();
    @(negedge clk);
    chk("c5_old_coef_data", longint'($signed(m_data)), 20);
    chk("c5_pend_blocks", longint'(s_ready), 0);
    wait_flush("cfg2");
    chk("cfg2_coef_bus", longint'(coef_bus), 64'h0004_0003_0002_FFFB);
    step(); s_valid = 1'b1; s_data = 24'd1;
    step(); s_data = 24'd0;
    @(negedge clk);
    chk("c5_new_tap0", longint'($signed(m_data)), -5);
    step(); s_valid = 1'b0;
    @(negedge clk);
    chk("c5_new_tap1", longint'($signed(m_data)), 2);
    step();

    // 6: reset in the middle of a flush
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    seen_flush = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy && chain_ena) begin
        seen_flush = 1'b1;
        break;
      end
      step();
    end
    chk("c6_flush_started", longint'(seen_flush), 1);
    step(); rst = 1'b0;
    step(); rst = 1'b1;
    @(negedge clk);
    chk("c6_busy", longint'(busy), 1);
    chk("c6_m_valid", longint'(m_valid), 0);
    chk("c6_coef_bus", longint'(coef_bus), 0);
    chk("c6_chain_ena", longint'(chain_ena), 0);
    step(); cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 16'd9;
    step(); cfg_addr = 3'd7; cfg_data = 16'h1234; cfg_commit = 1'b1;
    step();
    clr_inputs();
    wait_flush("cfg3");
    chk("cfg3_coef_bus", longint'(coef_bus), 64'h0000_0000_0009_0000);
    step(); s_valid = 1'b1; s_data = 24'd1;
    step(); s_data = 24'd0;
    @(negedge clk);
    chk("c6_tap0", longint'($signed(m_data)), 0);
    step(); s_valid = 1'b0;
    @(negedge clk);
    chk("c6_tap1", longint'($signed(m_data)), 9);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
